// File: rtl/boruss_fetch_if.sv
// ============================================================================
//  Module      : boruss_fetch_if
//  Description : Fetch-stage bus bundle for the Boruss CPU. It carries the
//                ROM address/data pair, the instruction handshake to decode,
//                and the redirect request from execute.
//                master = fetch stage, slave = ROM/decode/execute side.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface boruss_fetch_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  // ROM port
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  // Instruction handshake to decode
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  // PC redirect from execute
  logic              redirect_en;
  logic [ADDR_W-1:0] redirect_addr;

  modport master (
    output rom_addr,
    input  rom_data,
    output instr_out,
    output instr_pc,
    output instr_valid,
    input  instr_ready,
    input  redirect_en,
    input  redirect_addr
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  instr_out,
    input  instr_pc,
    input  instr_valid,
    output instr_ready,
    output redirect_en,
    output redirect_addr
  );
endinterface

`default_nettype wire

// File: rtl/boruss_fetch.sv
// ============================================================================
//  Module      : boruss_fetch
//  Description : Instruction fetch stage for the Boruss CPU. Owns the PC,
//                addresses the combinational program ROM, registers the byte
//                into an instruction register and offers it to decode over a
//                valid/ready handshake. Execute may redirect the PC at any
//                time; a redirect flushes the instruction register.
//  Options     : BORUSS_FETCH_HALT_EN - when defined, loading HALT_OPCODE
//                parks the stage in HALT until a redirect or reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module boruss_fetch #(
  parameter int                   ADDR_W      = 8,
  parameter int                   DATA_W      = 8,
  parameter logic [ADDR_W-1:0]    RESET_PC    = 8'h00,
  parameter logic [DATA_W-1:0]    HALT_OPCODE = 8'hFF
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               fetch_en,
  boruss_fetch_if.master          bus,
  output logic                    halted,
  output logic [15:0]             fetch_count
);

`ifdef BORUSS_FETCH_HALT_EN
  localparam bit HALT_ENABLE = 1'b1;
`else
  localparam bit HALT_ENABLE = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic [DATA_W-1:0]   instr_q;
  logic [ADDR_W-1:0]   instr_pc_q;
  logic                instr_valid_q;

  logic                load;
  logic                transfer;
  logic                halt_hit;
  logic [ADDR_W-1:0]   pc_next_seq;

  // The ROM is addressed directly by the PC; its data returns this cycle.
  assign bus.rom_addr    = pc;
  assign bus.instr_out   = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;

  // A load needs the FETCH state, fetching still enabled this cycle, a free
  // (or simultaneously drained) instruction register, and no redirect.
  assign load = (state == S_FETCH) && fetch_en &&
                (!instr_valid_q || bus.instr_ready) && !bus.redirect_en;

  // A redirect drops the held instruction, so it is never counted.
  assign transfer = instr_valid_q && bus.instr_ready && !bus.redirect_en;

  // Halt opcode only matters when the halt option is built in.
  assign halt_hit = HALT_ENABLE && (bus.rom_data == HALT_OPCODE);

  // Sequential successor wraps naturally at 2^ADDR_W.
  assign pc_next_seq = pc + {{(ADDR_W-1){1'b0}}, 1'b1};

  // Delivered-instruction counter, sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= 16'h0000;
    end else if (transfer && (fetch_count != 16'hFFFF)) begin
      fetch_count <= fetch_count + 16'd1;
    end
  end

  // Fetch FSM with PC, instruction register and halt flag as registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      pc            <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      halted        <= 1'b0;
    end else if (bus.redirect_en) begin
      // Redirect wins over everything, including HALT.
      pc            <= bus.redirect_addr;
      instr_valid_q <= 1'b0;
      halted        <= 1'b0;
      state         <= fetch_en ? S_FETCH : S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (fetch_en) state <= S_FETCH;
        end
        S_FETCH: begin
          if (!fetch_en) begin
            state <= S_IDLE;
          end else if (load && halt_hit) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end
        end
        S_HALT: begin
          // Parked until redirect or reset.
          state <= S_HALT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      if (load) begin
        instr_q       <= bus.rom_data;
        instr_pc_q    <= pc;
        instr_valid_q <= 1'b1;
        // The halt opcode is still presented, but the PC stays on it.
        if (!halt_hit) pc <= pc_next_seq;
      end else if (instr_valid_q && bus.instr_ready) begin
        instr_valid_q <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_boruss_fetch.sv
// ============================================================================
//  Module      : tb_boruss_fetch
//  Description : Directed self-checking bench for boruss_fetch. A behavioural
//                256x8 ROM answers the fetch address combinationally.
//                Halt behaviour follows BORUSS_FETCH_HALT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_boruss_fetch;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        halted;
  logic [15:0] fetch_count;
  logic [7:0]  rom [256];

  int n_cmp;
  int n_err;

  boruss_fetch_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  boruss_fetch #(
    .ADDR_W      (8),
    .DATA_W      (8),
    .RESET_PC    (8'h00),
    .HALT_OPCODE (8'hFF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (fetch_en),
    .bus         (bus),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  assign bus.rom_data = rom[bus.rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[8'h00] = 8'h00; rom[8'h01] = 8'h11; rom[8'h02] = 8'h22; rom[8'h03] = 8'h33;
    rom[8'h04] = 8'h44;
    rom[8'h10] = 8'hA0; rom[8'h11] = 8'hA1;
    rom[8'h12] = 8'hFF;
    rom[8'hFE] = 8'h01; rom[8'hFF] = 8'h02;

    rst_n             = 1'b1;
    fetch_en          = 1'b0;
    bus.instr_ready   = 1'b0;
    bus.redirect_en   = 1'b0;
    bus.redirect_addr = 8'h00;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(bus.instr_valid), 32'h0);
    check("rst_pc",    32'(bus.rom_addr),    32'h00);
    check("rst_out",   32'(bus.instr_out),   32'h00);
    check("rst_ipc",   32'(bus.instr_pc),    32'h00);
    check("rst_cnt",   32'(fetch_count),     32'h0);
    check("rst_halt",  32'(halted),          32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Sequential fetch with decode always ready: IDLE->FETCH takes one edge
    fetch_en        = 1'b1;
    bus.instr_ready = 1'b1;
    tick();
    check("idle_to_fetch_valid", 32'(bus.instr_valid), 32'h0);
    tick(); check("seq0_out", 32'(bus.instr_out), 32'h00); check("seq0_ipc", 32'(bus.instr_pc), 32'h00);
    tick(); check("seq1_out", 32'(bus.instr_out), 32'h11); check("seq1_ipc", 32'(bus.instr_pc), 32'h01);
    tick(); check("seq2_out", 32'(bus.instr_out), 32'h22); check("seq2_ipc", 32'(bus.instr_pc), 32'h02);
    tick(); check("seq3_out", 32'(bus.instr_out), 32'h33); check("seq3_ipc", 32'(bus.instr_pc), 32'h03);
    tick();
    check("seq_cnt4",  32'(fetch_count),   32'h4);
    check("seq4_out",  32'(bus.instr_out), 32'h44);

    // Redirect while a valid instruction is being accepted: it is dropped
    bus.redirect_en   = 1'b1;
    bus.redirect_addr = 8'h10;
    tick();
    bus.redirect_en = 1'b0;
    check("redir_valid", 32'(bus.instr_valid), 32'h0);
    check("redir_cnt",   32'(fetch_count),     32'h4);
    check("redir_pc",    32'(bus.rom_addr),    32'h10);
    tick();
    check("redir_tgt_ipc", 32'(bus.instr_pc),  32'h10);
    check("redir_tgt_out", 32'(bus.instr_out), 32'hA0);

    // Stall for three cycles: everything held, no counting
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_out", 32'(bus.instr_out), 32'hA0);
      check("stall_ipc", 32'(bus.instr_pc),  32'h10);
      check("stall_pc",  32'(bus.rom_addr),  32'h11);
      check("stall_cnt", 32'(fetch_count),   32'h4);
    end
    bus.instr_ready = 1'b1;
    tick();
    check("resume_out", 32'(bus.instr_out), 32'hA1);
    check("resume_cnt", 32'(fetch_count),   32'h5);

    // PC wrap from FF to 00
    bus.redirect_en   = 1'b1;
    bus.redirect_addr = 8'hFE;
    tick();
    bus.redirect_en = 1'b0;
    check("wrap_drop_cnt", 32'(fetch_count), 32'h5);
    tick(); check("wrap_fe_ipc", 32'(bus.instr_pc), 32'hFE); check("wrap_fe_out", 32'(bus.instr_out), 32'h01);
    tick(); check("wrap_ff_ipc", 32'(bus.instr_pc), 32'hFF); check("wrap_ff_out", 32'(bus.instr_out), 32'h02);
    check("wrap_pc00", 32'(bus.rom_addr), 32'h00);
    tick(); check("wrap_00_ipc", 32'(bus.instr_pc), 32'h00);
    check("wrap_cnt", 32'(fetch_count), 32'h7);

    // fetch_en low: no load, held instruction kept in IDLE until consumed
    fetch_en        = 1'b0;
    bus.instr_ready = 1'b0;
    tick();
    check("idle_hold_valid", 32'(bus.instr_valid), 32'h1);
    check("idle_hold_ipc",   32'(bus.instr_pc),    32'h00);
    check("idle_pc",         32'(bus.rom_addr),    32'h01);
    bus.instr_ready = 1'b1;
    tick();
    check("idle_consume_valid", 32'(bus.instr_valid), 32'h0);
    check("idle_consume_cnt",   32'(fetch_count),     32'h8);
    check("idle_no_load_pc",    32'(bus.rom_addr),    32'h01);
    fetch_en = 1'b1;
    tick();
    check("refetch_gap_valid", 32'(bus.instr_valid), 32'h0);
    tick();
    check("refetch_ipc", 32'(bus.instr_pc),  32'h01);
    check("refetch_out", 32'(bus.instr_out), 32'h11);

    // Halt opcode at 0x12
    bus.redirect_en   = 1'b1;
    bus.redirect_addr = 8'h12;
    tick();
    bus.redirect_en = 1'b0;
    check("halt_drop_cnt", 32'(fetch_count), 32'h8);
    tick();
    check("halt_op_out",   32'(bus.instr_out),   32'hFF);
    check("halt_op_valid", 32'(bus.instr_valid), 32'h1);
`ifdef BORUSS_FETCH_HALT_EN
    check("halt_flag", 32'(halted),       32'h1);
    check("halt_pc",   32'(bus.rom_addr), 32'h12);
    tick();
    check("halt_consume_cnt", 32'(fetch_count),     32'h9);
    check("halt_no_fetch",    32'(bus.instr_valid), 32'h0);
    tick();
    check("halt_still_idle",  32'(bus.instr_valid), 32'h0);
    check("halt_still_flag",  32'(halted),          32'h1);
    check("halt_still_pc",    32'(bus.rom_addr),    32'h12);
    bus.redirect_en   = 1'b1;
    bus.redirect_addr = 8'h00;
    tick();
    bus.redirect_en = 1'b0;
    check("unhalt_flag", 32'(halted),       32'h0);
    check("unhalt_pc",   32'(bus.rom_addr), 32'h00);
    tick();
    check("unhalt_ipc",   32'(bus.instr_pc),    32'h00);
    check("unhalt_valid", 32'(bus.instr_valid), 32'h1);
`else
    check("nohalt_flag", 32'(halted),       32'h0);
    check("nohalt_pc",   32'(bus.rom_addr), 32'h13);
    tick();
    check("nohalt_next_ipc", 32'(bus.instr_pc), 32'h13);
    check("nohalt_cnt",      32'(fetch_count),  32'h9);
    check("nohalt_flag2",    32'(halted),       32'h0);
`endif

    // Asynchronous reset in the middle of a stall
    bus.instr_ready = 1'b0;
    tick();
    check("pre_rst_valid", 32'(bus.instr_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.instr_valid), 32'h0);
    check("arst_pc",    32'(bus.rom_addr),    32'h00);
    check("arst_cnt",   32'(fetch_count),     32'h0);
    check("arst_halt",  32'(halted),          32'h0);
    tick();
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
